fp16_exp_norm: RTL and testbench

Downstream stage of the exponent adder in the half-precision floating-point multiplier. It consumes the raw exponent sum (6-bit sum plus carry-out), the operand signs and the 22-bit mantissa product. It removes the bias, normalizes, rounds to nearest-even and packs the result word. It is a 2-stage valid/ready pipeline and absorbs output backpressure without losing data.

---
 rtl/fp16_exp_norm.sv | 149 ++++++++++++++
 tb/tb_fp16_exp_norm.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_exp_norm.sv
// Half-precision multiplier back end: unbias, normalize, round-to-nearest-even, pack.
// Two-stage valid/ready pipeline; stage 1 aligns the product, stage 2 rounds and classifies.
module fp16_exp_norm #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10,
   parameter int BIAS  = 15
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [EXP_W:0]           exp_sum,
   input  logic                     exp_cout,
   input  logic                     sign_a,
   input  logic                     sign_b,
   input  logic                     in_zero,
   input  logic [2*(MAN_W+1)-1:0]   mant_prod,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [EXP_W+MAN_W:0]     result,
   output logic                     ovf,
   output logic                     unf
);

   localparam int PW = 2 * (MAN_W + 1);
   localparam int RW = 1 + EXP_W + MAN_W;
   localparam int EW = EXP_W + 4;

   localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0] E_ZERO = '0;
   localparam logic signed [EW-1:0] E_ONE  = EW'(1);
   localparam logic signed [EW-1:0] E_BIAS = EW'(BIAS);

   typedef struct packed {
      logic                   sign;
      logic signed [EW-1:0]   e;
      logic [MAN_W-1:0]       frac;
      logic                   guard;
      logic                   sticky;
      logic                   zero;
   } s1_t;

   s1_t                    s1_d;
   s1_t                    s1_q;
   logic                   s1_valid;
   logic                   advance;
   logic                   accept;
   logic signed [EW-1:0]   e_base;

   logic                   rnd;
   logic [MAN_W:0]         frac_sum;
   logic [MAN_W-1:0]       frac_n;
   logic signed [EW-1:0]   e_n;
   logic                   is_zero;
   logic                   is_ovf;
   logic                   is_unf;
   logic [RW-1:0]          res_d;
   logic                   ovf_d;
   logic                   unf_d;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance || !s1_valid;
   assign accept   = in_valid && in_ready;

   // Stage 1: remove bias and align so the hidden bit sits just above frac
   always_comb begin
      s1_d      = '0;
      s1_d.sign = sign_a ^ sign_b;
      s1_d.zero = in_zero;
      e_base    = EW'({exp_cout, exp_sum}) - E_BIAS;
      if (mant_prod[PW-1]) begin
         s1_d.e      = e_base + E_ONE;
         s1_d.frac   = mant_prod[PW-2 -: MAN_W];
         s1_d.guard  = mant_prod[PW-2-MAN_W];
         s1_d.sticky = |mant_prod[PW-3-MAN_W:0];
      end else begin
         s1_d.e      = e_base;
         s1_d.frac   = mant_prod[PW-3 -: MAN_W];
         s1_d.guard  = mant_prod[PW-3-MAN_W];
         s1_d.sticky = |mant_prod[PW-4-MAN_W:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_q     <= s1_d;
      end else if (advance) begin
         s1_valid <= 1'b0;
      end
   end

   // Stage 2: round to nearest even; an all-ones carry bumps the exponent
   always_comb begin
      rnd      = s1_q.guard & (s1_q.sticky | s1_q.frac[0]);
      frac_sum = {1'b0, s1_q.frac} + {{MAN_W{1'b0}}, rnd};
      if (frac_sum[MAN_W]) begin
         frac_n = '0;
         e_n    = s1_q.e + E_ONE;
      end else begin
         frac_n = frac_sum[MAN_W-1:0];
         e_n    = s1_q.e;
      end
   end

   assign is_zero = s1_q.zero;
   assign is_ovf  = !s1_q.zero && (e_n >= E_MAX);
   assign is_unf  = !s1_q.zero && (e_n <= E_ZERO);

   always_comb begin
      res_d = {s1_q.sign, e_n[EXP_W-1:0], frac_n};
      ovf_d = 1'b0;
      unf_d = 1'b0;
      unique case (1'b1)
         is_zero: begin
            res_d = {s1_q.sign, {(RW-1){1'b0}}};
         end
         is_ovf: begin
            res_d = {s1_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ovf_d = 1'b1;
         end
         is_unf: begin
            res_d = {s1_q.sign, {(RW-1){1'b0}}};
            unf_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         ovf       <= 1'b0;
         unf       <= 1'b0;
      end else if (advance) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            result <= res_d;
            ovf    <= ovf_d;
            unf    <= unf_d;
         end
      end
   end

endmodule

// File: tb/tb_fp16_exp_norm.sv
// Bench for fp16_exp_norm: directed vectors, backpressure, reset and random traffic
// scored against an integer-arithmetic model of the rounding rules.
module tb_fp16_exp_norm;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  exp_sum;
   logic        exp_cout;
   logic        sign_a;
   logic        sign_b;
   logic        in_zero;
   logic [21:0] mant_prod;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic        ovf;
   logic        unf;

   int          n_chk = 0;
   int          n_fail = 0;
   int          n_in = 0;
   int          n_out = 0;
   logic [17:0] q[$];

   fp16_exp_norm dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .exp_sum   (exp_sum),
      .exp_cout  (exp_cout),
      .sign_a    (sign_a),
      .sign_b    (sign_b),
      .in_zero   (in_zero),
      .mant_prod (mant_prod),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .ovf       (ovf),
      .unf       (unf)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Value-level model: {result, ovf, unf}
   function automatic logic [17:0] model(input logic [5:0] es, input logic c,
                                         input logic sa, input logic sb,
                                         input logic z, input logic [21:0] p);
      int e, sh, m, rem, half, pv;
      logic s;
      logic [15:0] r;
      pv = int'(p);
      e = int'(es) + (c ? 64 : 0) - 15;
      sh = (pv >= (1 << 21)) ? 11 : 10;
      if (sh == 11) e++;
      m = pv >> sh;
      rem = pv % (1 << sh);
      half = 1 << (sh - 1);
      if (rem > half || (rem == half && (m % 2) == 1)) m++;
      if (m == 2048) begin
         m = 1024;
         e++;
      end
      s = sa ^ sb;
      if (z) return {s, 15'd0, 2'b00};
      if (e >= 31) return {s, 5'h1f, 10'd0, 2'b10};
      if (e <= 0) return {s, 15'd0, 2'b01};
      r = {s, 5'(e), 10'(m)};
      return {r, 2'b00};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [5:0] es, input logic c, input logic sa,
                        input logic sb, input logic z, input logic [21:0] p);
      exp_sum   = es;
      exp_cout  = c;
      sign_a    = sa;
      sign_b    = sb;
      in_zero   = z;
      mant_prod = p;
   endtask

   // One clock: score the handshakes that fire at the coming edge
   task automatic tick();
      logic [17:0] e;
      #1;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         n_out++;
         check("scb_nonempty", 32'(q.size() > 0), 32'd1);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("scb_data", {14'd0, result, ovf, unf}, {14'd0, e});
         end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
         n_in++;
         q.push_back(model(exp_sum, exp_cout, sign_a, sign_b, in_zero,
                           mant_prod));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int k = 0; k < 200 && q.size() > 0; k++) tick();
      check("drain_empty", 32'(q.size()), 32'd0);
   endtask

   task automatic directed(input string tag, input logic [5:0] es,
                           input logic c, input logic sa, input logic sb,
                           input logic z, input logic [21:0] p,
                           input logic [15:0] er, input logic eo,
                           input logic eu);
      int n0;
      n0 = n_in;
      out_ready = 1'b1;
      drive(es, c, sa, sb, z, p);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check({tag, "_acc"}, 32'(n_in - n0), 32'd1);
      check({tag, "_lat1"}, 32'(out_valid), 32'd0);
      tick();
      check({tag, "_lat2"}, 32'(out_valid), 32'd1);
      check(tag, {14'd0, result, ovf, unf}, {14'd0, er, eo, eu});
      tick();
   endtask

   initial begin
      logic [15:0] held;
      logic [21:0] p;
      int n0;

      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      drive(6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 22'h100000);
      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", {14'd0, result, ovf, unf}, 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      directed("one", 6'd30, 0, 0, 0, 0, 22'h100000, 16'h3C00, 0, 0);
      directed("norm", 6'd30, 0, 0, 0, 0, 22'h240000, 16'h4080, 0, 0);
      directed("rnd_carry", 6'd30, 0, 0, 0, 0, 22'h1FFE00, 16'h4000, 0, 0);
      directed("no_guard", 6'd30, 0, 0, 0, 0, 22'h1FFC00, 16'h3FFF, 0, 0);
      directed("tie_odd", 6'd30, 0, 0, 0, 0, 22'h100600, 16'h3C02, 0, 0);
      directed("tie_even", 6'd30, 0, 0, 0, 0, 22'h100200, 16'h3C00, 0, 0);
      directed("sticky", 6'd30, 0, 0, 0, 0, 22'h100201, 16'h3C01, 0, 0);
      directed("ovf", 6'd60, 0, 1, 0, 0, 22'h100000, 16'hFC00, 1, 0);
      directed("unf", 6'd2, 0, 0, 0, 0, 22'h100000, 16'h0000, 0, 1);
      directed("zero", 6'd30, 0, 0, 1, 1, 22'h100000, 16'h8000, 0, 0);
      directed("e31", 6'd46, 0, 0, 0, 0, 22'h100000, 16'h7C00, 1, 0);
      directed("e30", 6'd45, 0, 0, 0, 0, 22'h100000, 16'h7800, 0, 0);
      directed("e0", 6'd15, 0, 0, 0, 0, 22'h100000, 16'h0000, 0, 1);
      directed("e1", 6'd16, 0, 0, 0, 0, 22'h100000, 16'h0400, 0, 0);
      directed("cout", 6'd0, 1, 0, 0, 0, 22'h100000, 16'h7C00, 1, 0);
      directed("rnd_to_ovf", 6'd45, 0, 0, 0, 0, 22'h1FFE00, 16'h7C00, 1, 0);
      directed("rnd_from_unf", 6'd15, 0, 0, 0, 0, 22'h1FFE00, 16'h0400, 0, 0);
      directed("shift_ovf", 6'd45, 0, 0, 0, 0, 22'h200000, 16'h7C00, 1, 0);

      // Backpressure: four beats against a stalled consumer
      n0 = n_out;
      out_ready = 1'b0;
      in_valid = 1'b1;
      drive(6'd30, 0, 0, 0, 0, 22'h100000);
      tick();
      check("bp_rdy1", 32'(in_ready), 32'd1);
      drive(6'd30, 0, 0, 0, 0, 22'h240000);
      tick();
      check("bp_rdy_low", 32'(in_ready), 32'd0);
      check("bp_ov", 32'(out_valid), 32'd1);
      held = result;
      drive(6'd31, 0, 1, 0, 0, 22'h180000);
      tick();
      check("bp_hold1", {16'd0, result}, {16'd0, held});
      check("bp_rdy_low2", 32'(in_ready), 32'd0);
      tick();
      check("bp_hold2", {16'd0, result}, {16'd0, held});
      out_ready = 1'b1;
      tick();
      drive(6'd40, 0, 0, 1, 0, 22'h300000);
      tick();
      in_valid = 1'b0;
      drain();
      check("bp_count", 32'(n_out - n0), 32'd4);

      // Random traffic with random backpressure
      n0 = n_out;
      for (int i = 0; i < 400; i++) begin
         p = 22'($urandom_range(1024, 2047) * $urandom_range(1024, 2047));
         drive(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 15) == 0), p);
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain();
      check("rand_traffic", 32'(n_out - n0 > 50), 32'd1);

      // Reset with both stages full
      out_ready = 1'b0;
      in_valid = 1'b1;
      drive(6'd30, 0, 0, 0, 0, 22'h100000);
      tick();
      tick();
      in_valid = 1'b0;
      check("full_ov", 32'(out_valid), 32'd1);
      check("full_rdy", 32'(in_ready), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_ov", 32'(out_valid), 32'd0);
      check("arst_res", {14'd0, result, ovf, unf}, 32'd0);
      q.delete();
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      directed("post_rst", 6'd30, 0, 0, 0, 0, 22'h240000, 16'h4080, 0, 0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
